// File: rtl/pe_sad_acc.sv
// pe_sad_acc: motion-estimation processing element with saturating SAD accumulator.
//
// Holds two current-block pixels (ping-pong banks) that are passed systolically to the
// neighbour PE, selects a reference pixel from four adjacent PEs, registers |curr - ref|
// and accumulates it into a saturating SAD over a BLK_LEN-sample window.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   in_curr1/2, in_curr_enable    current pixel banks and their load strobe
//   CB_select                     active bank (1 = bank 1, 0 = bank 2)
//   abs_Control                   00 update, 01/11 hold, 10 clear abs_out
//   up_/down_ref_adajecent_1/8    reference candidates from neighbour PEs
//   change_ref, ref_input_Control reference load strobe and source select
//   start, acc_en                 window start (IDLE only) and per-sample accept
//   abs_out                       registered absolute difference
//   next_pix1/2, ref_pix          registers forwarded to neighbour PEs
//   sad_out, sad_valid, busy      completed SAD, one-cycle strobe, window in progress
//
// Note: ACC_W should be >= PIXEL_W + clog2(BLK_LEN); narrower accumulators are legal and
// simply saturate earlier.
module pe_sad_acc #(
  parameter int unsigned PIXEL_W = 8,
  parameter int unsigned ACC_W   = 16,
  parameter int unsigned BLK_LEN = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PIXEL_W-1:0] in_curr1,
  input  logic [PIXEL_W-1:0] in_curr2,
  input  logic               in_curr_enable,
  input  logic               CB_select,
  input  logic [1:0]         abs_Control,
  input  logic [PIXEL_W-1:0] up_ref_adajecent_1,
  input  logic [PIXEL_W-1:0] up_ref_adajecent_8,
  input  logic [PIXEL_W-1:0] down_ref_adajecent_1,
  input  logic [PIXEL_W-1:0] down_ref_adajecent_8,
  input  logic               change_ref,
  input  logic [1:0]         ref_input_Control,
  input  logic               start,
  input  logic               acc_en,
  output logic [PIXEL_W-1:0] abs_out,
  output logic [PIXEL_W-1:0] next_pix1,
  output logic [PIXEL_W-1:0] next_pix2,
  output logic [PIXEL_W-1:0] ref_pix,
  output logic [ACC_W-1:0]   sad_out,
  output logic               sad_valid,
  output logic               busy
);

  localparam int unsigned CNT_W = $clog2(BLK_LEN);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(BLK_LEN - 1);
  localparam logic [ACC_W-1:0] AccMax  = '1;

  typedef enum logic [0:0] {StIdle, StAcc} state_e;

  state_e             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [PIXEL_W-1:0] curr_sel;
  logic [PIXEL_W-1:0] ref_sel;
  logic [PIXEL_W:0]   diff;
  logic [PIXEL_W:0]   diff_neg;
  logic [PIXEL_W-1:0] abs_val;
  logic [ACC_W:0]     abs_ext;
  logic [ACC_W:0]     sum_full;
  logic [ACC_W-1:0]   acc_sat;

  always_comb begin
    curr_sel = CB_select ? next_pix1 : next_pix2;

    ref_sel = up_ref_adajecent_1;
    unique case (ref_input_Control)
      2'b00: ref_sel = up_ref_adajecent_1;
      2'b01: ref_sel = up_ref_adajecent_8;
      2'b10: ref_sel = down_ref_adajecent_1;
      2'b11: ref_sel = down_ref_adajecent_8;
      default: ref_sel = up_ref_adajecent_1;
    endcase

    // One extra bit keeps the sign; the magnitude always fits PIXEL_W.
    diff     = {1'b0, curr_sel} - {1'b0, ref_pix};
    diff_neg = -diff;
    abs_val  = diff[PIXEL_W] ? diff_neg[PIXEL_W-1:0] : diff[PIXEL_W-1:0];

    // Carry-out of the widened add flags overflow; once clamped, adding a non-negative
    // value keeps the result clamped.
    abs_ext  = {{(ACC_W + 1 - PIXEL_W){1'b0}}, abs_out};
    sum_full = {1'b0, acc_q} + abs_ext;
    acc_sat  = sum_full[ACC_W] ? AccMax : sum_full[ACC_W-1:0];
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_pix1 <= '0;
      next_pix2 <= '0;
      ref_pix   <= '0;
      abs_out   <= '0;
    end else begin
      if (in_curr_enable) begin
        next_pix1 <= in_curr1;
        next_pix2 <= in_curr2;
      end
      if (change_ref) begin
        ref_pix <= ref_sel;
      end
      unique case (abs_Control)
        2'b00:   abs_out <= abs_val;
        2'b10:   abs_out <= '0;
        default: abs_out <= abs_out;
      endcase
    end
  end

  // SAD window FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      cnt_q     <= '0;
      sad_out   <= '0;
      sad_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      sad_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StAcc;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy    <= 1'b1;
          end
        end
        StAcc: begin
          if (acc_en) begin
            acc_q <= acc_sat;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CntLast) begin
              sad_out   <= acc_sat;
              sad_valid <= 1'b1;
              busy      <= 1'b0;
              state_q   <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
